// File: rtl/audio_voice_mixer_if.sv
// Avalon-MM register-write port for audio_voice_mixer.
// The host side drives it through 'master'; the mixer receives it through 'slave'.
interface audio_voice_mixer_if #(
    parameter int unsigned AW = 4
);
    logic          chipselect;
    logic          write;
    logic [AW-1:0] address;
    logic [15:0]   writedata;

    modport master (output chipselect, write, address, writedata);
    modport slave  (input  chipselect, write, address, writedata);
endinterface

// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer: multi-voice sample player sharing one sample ROM.
// For each codec sample request it visits every voice in index order.
// Per voice it issues one ROM read, waits ROM_LAT cycles, scales the data by
// the voice volume and adds it to a wide accumulator. The sum is saturated
// to SAMPLE_W bits and presented on audio_output with a sample_valid pulse.
// Optional feature: define VOICE_IRQ_EN to enable the per-voice done flags
// and irq. Without it, done and irq stay 0.
module audio_voice_mixer #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    audio_voice_mixer_if.slave         avs,
    input  logic                       sample_req,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic signed [SAMPLE_W-1:0] rom_q,
    output logic signed [SAMPLE_W-1:0] audio_output,
    output logic                       sample_valid,
    output logic                       overrun,
    output logic                       irq
);

    localparam int unsigned AW     = $clog2(NUM_VOICES) + 2;
    localparam int unsigned VW     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int unsigned PROD_W = SAMPLE_W + 9;
    localparam int unsigned CW     = 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]                 r_state;
    logic [2:0]                 w_state_nxt;
    logic [VW-1:0]              r_voice;
    logic [CW-1:0]              r_wait_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic [ADDR_W-1:0]          r_rom_addr;
    logic signed [SAMPLE_W-1:0] r_audio;
    logic                       r_valid;
    logic                       r_overrun;
    logic                       r_irq;

    logic [ADDR_W-1:0]          r_start [NUM_VOICES];
    logic [15:0]                r_len   [NUM_VOICES];
    logic [15:0]                r_pos   [NUM_VOICES];
    logic [7:0]                 r_vol   [NUM_VOICES];
    logic [NUM_VOICES-1:0]      r_play;
    logic [NUM_VOICES-1:0]      r_loop;
    logic [NUM_VOICES-1:0]      w_done;

    logic                       w_last_voice;
    logic                       w_wait_done;
    logic [AW-1:0]              w_addr;
    logic [AW-1:0]              w_addr_voice;
    logic [VW-1:0]              w_wr_voice;
    logic [1:0]                 w_wr_reg;
    logic                       w_wr;
    logic [ADDR_W-1:0]          w_fetch_addr;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [PROD_W-1:0]   w_scaled;
    logic signed [ACC_W-1:0]    w_contrib;
    logic signed [SAMPLE_W-1:0] w_sat;
    logic                       w_cur_active;
    logic                       w_unused;

`ifdef VOICE_IRQ_EN
    logic [NUM_VOICES-1:0]      r_done;
    assign w_done = r_done;
`else
    assign w_done = '0;
`endif

    // Host write decode: {voice, reg}; writes to nonexistent voices are dropped.
    assign w_addr       = avs.address;
    assign w_addr_voice = w_addr >> 2;
    assign w_wr_voice   = VW'(w_addr_voice);
    assign w_wr_reg     = w_addr[1:0];
    assign w_wr         = avs.chipselect && avs.write && (w_addr_voice < AW'(NUM_VOICES));
    assign w_unused     = ^avs.writedata[7:2];

    // Sequencer conditions.
    assign w_last_voice = (r_voice == VW'(NUM_VOICES - 1));
    assign w_wait_done  = (r_wait_cnt == CW'(ROM_LAT - 1));

    // Datapath for the voice being visited: address, volume scaling, saturation.
    assign w_fetch_addr = r_start[r_voice] + ADDR_W'(r_pos[r_voice]);
    assign w_prod       = PROD_W'(rom_q) * PROD_W'($signed({1'b0, r_vol[r_voice]}));
    assign w_scaled     = w_prod >>> 8;
    assign w_cur_active = r_play[r_voice] && (r_len[r_voice] != 16'd0);
    assign w_contrib    = w_cur_active ? ACC_W'(w_scaled) : '0;
    assign w_sat        = (r_acc > SAT_MAX) ? SAMPLE_W'(SAT_MAX) :
                          (r_acc < SAT_MIN) ? SAMPLE_W'(SAT_MIN) :
                                              SAMPLE_W'(r_acc);

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (sample_req) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_wait_done) w_state_nxt = S_ACC;
            S_ACC:   w_state_nxt = w_last_voice ? S_OUT : S_FETCH;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Voice index and ROM wait counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_voice    <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_voice <= '0;
            end else if (r_state == S_ACC && !w_last_voice) begin
                r_voice <= r_voice + VW'(1);
            end
            if (r_state == S_FETCH) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end
    end

    // ROM address, accumulator and output sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rom_addr <= '0;
            r_acc      <= '0;
            r_audio    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == S_FETCH) begin
                r_rom_addr <= w_fetch_addr;
            end
            if (r_state == S_ACC) begin
                r_acc <= r_acc + w_contrib;
            end
            if (r_state == S_OUT) begin
                r_audio <= w_sat;
                r_valid <= 1'b1;
                r_acc   <= '0;
            end
        end
    end

    // Sticky overrun flag and irq level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (sample_req && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end else if (w_wr && w_wr_voice == '0 && w_wr_reg == 2'd3 && avs.writedata[15]) begin
                r_overrun <= 1'b0;
            end
            r_irq <= |w_done;
        end
    end

    // Per-voice registers: playback advance in ACC, then host writes, which take priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_start[v] <= '0;
                r_len[v]   <= '0;
                r_pos[v]   <= '0;
                r_vol[v]   <= '0;
            end
            r_play <= '0;
            r_loop <= '0;
`ifdef VOICE_IRQ_EN
            r_done <= '0;
`endif
        end else begin
            if (r_state == S_ACC && r_play[r_voice]) begin
                if (r_len[r_voice] == 16'd0 || r_pos[r_voice] == r_len[r_voice] - 16'd1) begin
                    if (r_loop[r_voice] && r_len[r_voice] != 16'd0) begin
                        r_pos[r_voice] <= '0;
                    end else begin
                        r_play[r_voice] <= 1'b0;
`ifdef VOICE_IRQ_EN
                        r_done[r_voice] <= 1'b1;
`endif
                    end
                end else begin
                    r_pos[r_voice] <= r_pos[r_voice] + 16'd1;
                end
            end
            if (w_wr) begin
                case (w_wr_reg)
                    2'd0: r_start[w_wr_voice] <= ADDR_W'(avs.writedata);
                    2'd1: r_len[w_wr_voice]   <= avs.writedata;
                    2'd2: begin
                        r_play[w_wr_voice] <= avs.writedata[0];
                        r_loop[w_wr_voice] <= avs.writedata[1];
                        r_vol[w_wr_voice]  <= avs.writedata[15:8];
                        // A (re)start also clears a done flag raised in the same cycle.
                        if (avs.writedata[0]) begin
                            r_pos[w_wr_voice] <= '0;
`ifdef VOICE_IRQ_EN
                            r_done[w_wr_voice] <= 1'b0;
`endif
                        end
                    end
                    default: begin
`ifdef VOICE_IRQ_EN
                        r_done[w_wr_voice] <= 1'b0;
`endif
                    end
                endcase
            end
        end
    end

    assign rom_addr     = r_rom_addr;
    assign audio_output = r_audio;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;
    assign irq          = r_irq;

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Testbench for audio_voice_mixer: directed scenarios and randomized voice
// setups checked against a per-sample behavioural model of the mixer.
`timescale 1ns/1ps
module tb_audio_voice_mixer;

    localparam int unsigned NV   = 4;
    localparam int unsigned SW   = 16;
    localparam int unsigned AWD  = 15;
    localparam int unsigned RL   = 1;
    localparam int unsigned AW   = $clog2(NV) + 2;
    localparam int          ROMN = 1 << AWD;
    localparam int          LAT  = NV * (RL + 2) + 1;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b1;
    logic                 sample_req = 1'b0;
    logic [AWD-1:0]       rom_addr;
    logic signed [SW-1:0] rom_q;
    logic signed [SW-1:0] audio_output;
    logic                 sample_valid;
    logic                 overrun;
    logic                 irq;

    audio_voice_mixer_if #(.AW(AW)) avs ();

    audio_voice_mixer #(
        .NUM_VOICES(NV), .SAMPLE_W(SW), .ADDR_W(AWD), .ROM_LAT(RL)
    ) dut (
        .clk(clk), .resetn(resetn), .avs(avs), .sample_req(sample_req),
        .rom_addr(rom_addr), .rom_q(rom_q), .audio_output(audio_output),
        .sample_valid(sample_valid), .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    // Synchronous sample ROM, one cycle of latency.
    logic signed [SW-1:0] rom [ROMN];
    always @(posedge clk) rom_q <= rom[rom_addr];

    // Behavioural model of the voice registers.
    int m_start [NV];
    int m_len   [NV];
    int m_pos   [NV];
    int m_vol   [NV];
    bit m_play  [NV];
    bit m_loop  [NV];
    bit m_done  [NV];

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_start[v] = 0; m_len[v] = 0; m_pos[v] = 0; m_vol[v] = 0;
            m_play[v] = 0; m_loop[v] = 0; m_done[v] = 0;
        end
    endtask

    task automatic model_write(input int v, input int r, input int d);
        case (r)
            0: m_start[v] = d & (ROMN - 1);
            1: m_len[v] = d & 16'hFFFF;
            2: begin
                m_play[v] = (d & 1) != 0;
                m_loop[v] = (d & 2) != 0;
                m_vol[v]  = (d >> 8) & 8'hFF;
                if (m_play[v]) begin
                    m_pos[v]  = 0;
                    m_done[v] = 0;
                end
            end
            default: m_done[v] = 0;
        endcase
    endtask

    // One whole mix: every playing voice contributes floor(rom*vol/256), then saturate.
    task automatic model_mix(output int y);
        int acc;
        acc = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_play[v]) begin
                if (m_len[v] == 0) begin
                    m_play[v] = 0;
                    m_done[v] = 1;
                end else begin
                    int s;
                    s = rom[(m_start[v] + m_pos[v]) % ROMN];
                    acc += (s * m_vol[v]) >>> 8;
                    if (m_pos[v] == m_len[v] - 1) begin
                        if (m_loop[v]) m_pos[v] = 0;
                        else begin
                            m_play[v] = 0;
                            m_done[v] = 1;
                        end
                    end else begin
                        m_pos[v] = (m_pos[v] + 1) & 16'hFFFF;
                    end
                end
            end
        end
        y = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
    endtask

    function automatic bit exp_irq();
        bit r;
        r = 1'b0;
`ifdef VOICE_IRQ_EN
        for (int v = 0; v < NV; v++) r |= m_done[v];
`endif
        return r;
    endfunction

    task automatic host_write(input int v, input int r, input int d);
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        avs.address    = AW'(v * 4 + r);
        avs.writedata  = 16'(d);
        tick();
        avs.chipselect = 1'b0;
        avs.write      = 1'b0;
        model_write(v, r, d);
    endtask

    // Pulse sample_req and wait (bounded) for sample_valid; lat=-1 on timeout.
    task automatic do_sample(output int val, output int lat);
        val = 0;
        lat = -1;
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (sample_valid) begin
                val = int'(audio_output);
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        model_reset();
        tick();
        checks++; if (audio_output !== 16'sd0) begin errors++; $display("FAIL reset_audio: got %0d expected 0", audio_output); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr); end
    endtask

    task automatic test_single_voice();
        int exp_vals [5] = '{500, -1000, 2000, 16383, 0};
        int val, lat, my;
        rom[16'h100] = 16'sd1000;
        rom[16'h101] = -16'sd2000;
        rom[16'h102] = 16'sd4000;
        rom[16'h103] = 16'sd32767;
        host_write(0, 0, 16'h100);
        host_write(0, 1, 4);
        host_write(0, 2, 16'h8001);
        for (int i = 0; i < 5; i++) begin
            do_sample(val, lat);
            model_mix(my);
            checks++; if (val !== exp_vals[i]) begin errors++; $display("FAIL single_sample%0d: got %0d expected %0d", i, val, exp_vals[i]); end
            if (i == 0) begin
                checks++; if (lat !== LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT); end
            end
            if (i == 3) begin
                checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL single_irq_done: got %b expected %b", irq, exp_irq()); end
            end
        end
        host_write(0, 3, 0);
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_loop_wrap();
        int exp_vals [5] = '{500, -1000, 2000, 16383, 500};
        int val, lat, my;
        host_write(0, 2, 16'h8003);
        for (int i = 0; i < 5; i++) begin
            do_sample(val, lat);
            model_mix(my);
            checks++; if (val !== exp_vals[i]) begin errors++; $display("FAIL loop_sample%0d: got %0d expected %0d", i, val, exp_vals[i]); end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL loop_irq: got %b expected 0", irq); end
        host_write(0, 2, 0);
    endtask

    task automatic test_saturation();
        int val, lat, my;
        rom[16'h200] = 16'sd32767;
        for (int v = 0; v < NV; v++) begin
            host_write(v, 0, 16'h200);
            host_write(v, 1, 1);
            host_write(v, 2, 16'hFF03);
        end
        do_sample(val, lat);
        model_mix(my);
        checks++; if (val !== 32767) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", val); end
        rom[16'h200] = -16'sd32768;
        do_sample(val, lat);
        model_mix(my);
        checks++; if (val !== -32768) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", val); end
        for (int v = 0; v < NV; v++) host_write(v, 2, 0);
    endtask

    task automatic test_overrun();
        int nvalid, my;
        nvalid = 0;
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        tick(); tick();
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (sample_valid) nvalid++;
        end
        model_mix(my);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        checks++; if (nvalid !== 1) begin errors++; $display("FAIL overrun_valid_count: got %0d expected 1", nvalid); end
        host_write(0, 3, 16'h8000);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_retrigger();
        int val, lat, my;
        rom[16'h300] = 16'sd1200;
        rom[16'h301] = -16'sd800;
        host_write(1, 0, 16'h300);
        host_write(1, 1, 2);
        host_write(1, 2, 16'h4001);
        do_sample(val, lat);
        model_mix(my);
        checks++; if (val !== my) begin errors++; $display("FAIL retrig_first: got %0d expected %0d", val, my); end
        // Second mix: voice 1 reaches its end in ACC on the 6th edge after the request edge.
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        repeat (2 * (RL + 2) - 1) tick();
        avs.chipselect = 1'b1; avs.write = 1'b1;
        avs.address = AW'(1 * 4 + 2); avs.writedata = 16'h4001;
        tick();
        avs.chipselect = 1'b0; avs.write = 1'b0;
        val = 0; lat = -1;
        for (int c = 2 * (RL + 2) + 1; c <= 40; c++) begin
            tick();
            if (sample_valid) begin val = int'(audio_output); lat = c; break; end
        end
        model_mix(my);
        model_write(1, 2, 16'h4001);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL retrig_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (val !== my) begin errors++; $display("FAIL retrig_collision: got %0d expected %0d", val, my); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL retrig_irq_clear: got %b expected 0", irq); end
        for (int i = 0; i < 2; i++) begin
            do_sample(val, lat);
            model_mix(my);
            checks++; if (val !== my) begin errors++; $display("FAIL retrig_replay%0d: got %0d expected %0d", i, val, my); end
        end
        checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL retrig_irq_end: got %b expected %b", irq, exp_irq()); end
        host_write(1, 3, 0);
    endtask

    task automatic test_random();
        int val, lat, my;
        for (int round = 0; round < 3; round++) begin
            for (int v = 0; v < NV; v++) begin
                host_write(v, 0, int'($urandom_range(0, ROMN - 1)));
                host_write(v, 1, int'($urandom_range(0, 5)));
                host_write(v, 2, int'(($urandom_range(0, 255) << 8) | $urandom_range(0, 3)));
            end
            for (int s = 0; s < 8; s++) begin
                if ($urandom_range(0, 3) == 0)
                    host_write(int'($urandom_range(0, NV - 1)), 3, 0);
                do_sample(val, lat);
                model_mix(my);
                checks++; if (val !== my) begin errors++; $display("FAIL random_r%0d_s%0d: got %0d expected %0d", round, s, val, my); end
                checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL random_irq_r%0d_s%0d: got %b expected %b", round, s, irq, exp_irq()); end
            end
        end
    endtask

    task automatic test_reset_mid_mix();
        int val, lat, my;
        host_write(2, 0, 16'h100);
        host_write(2, 1, 4);
        host_write(2, 2, 16'h8003);
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        checks++; if (audio_output !== 16'sd0) begin errors++; $display("FAIL midrst_audio: got %0d expected 0", audio_output); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL midrst_rom_addr: got %0h expected 0", rom_addr); end
        tick();
        resetn = 1'b1;
        model_reset();
        tick();
        do_sample(val, lat);
        model_mix(my);
        checks++; if (val !== 0) begin errors++; $display("FAIL midrst_after: got %0d expected 0", val); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
    endtask

    initial begin
        avs.chipselect = 1'b0;
        avs.write      = 1'b0;
        avs.address    = '0;
        avs.writedata  = '0;
        for (int i = 0; i < ROMN; i++) rom[i] = SW'($urandom);
        model_reset();
        #2;
        test_reset();
        test_single_voice();
        test_loop_wrap();
        test_saturation();
        test_overrun();
        test_retrigger();
        test_random();
        test_reset_mid_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_voice_mixer.md
Name: audio_voice_mixer

Overview:
- Parametrised multi-voice sound-effect player; successor to the single-clip, on/off audio sample fetcher.
- Plays up to NUM_VOICES independent clips from one shared sample ROM, time-multiplexing ROM reads across voices.
- Each voice has its own start address, length, loop mode and 8-bit volume, written from the HPS over the Avalon slave.
- Sits between the sample ROM and the audio codec interface. Produces one mixed, saturated 16-bit sample per codec sample request.

Parameters:
- NUM_VOICES, 4: number of voices, 1..8.
- SAMPLE_W, 16: signed sample width of ROM data and output.
- ADDR_W, 15: ROM address width.
- ROM_LAT, 1: cycles from rom_addr driven to rom_q valid, 1..3.

Ports:
- clk  in  1  audio clock; the codec sample_req/sample_end are in this domain.
- resetn  in  1  asynchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- address  in  $clog2(NUM_VOICES)+2  register index {voice, reg[1:0]}.
- writedata  in  16  write data.
- sample_req  in  1  one-cycle pulse from the codec requesting the next sample.
- rom_addr  out  ADDR_W  shared ROM address.
- rom_q  in  SAMPLE_W  ROM data, signed.
- audio_output  out  SAMPLE_W  mixed sample, held between updates.
- sample_valid  out  1  one-cycle pulse when audio_output updates.
- overrun  out  1  sticky; set when sample_req arrives while a mix is in progress.
- irq  out  1  level; OR of per-voice done flags.

Behaviour:
- Reset: all registers cleared. Outputs audio_output=0, sample_valid=0, overrun=0, irq=0, rom_addr=0. FSM=IDLE.
- Register map (writes only, when chipselect&&write):
  - reg0: start address, writedata[ADDR_W-1:0].
  - reg1: length in samples, 16 bit.
  - reg2: control. bit0 play, bit1 loop, bits[15:8] volume.
    - Writing play=1 sets pos=0 and starts or restarts the voice.
    - Writing play=0 stops the voice; no done flag.
  - reg3: write any value clears that voice's done flag. Voice 0 reg3 with writedata[15]=1 also clears overrun.
- FSM: IDLE -> FETCH(v) -> WAIT(v) for ROM_LAT cycles -> ACC(v), then v+1 back to FETCH. After the last voice -> OUT -> IDLE.
  - IDLE->FETCH(0) on sample_req.
  - FETCH drives rom_addr = start+pos (mod 2^ADDR_W).
  - ACC for a playing voice: acc += (rom_q * volume) >>> 8. rom_q is signed, volume unsigned; arithmetic shift.
  - ACC for a non-playing voice: adds 0 and does not advance.
  - OUT: saturate acc to SAMPLE_W signed range, register it to audio_output, pulse sample_valid, clear acc.
- Latency: sample_valid asserts NUM_VOICES*(ROM_LAT+2)+1 cycles after sample_req. Default is 13 cycles.
- Accumulator width: SAMPLE_W+$clog2(NUM_VOICES)+1; no intermediate wrap.
- Position update, in ACC of a playing voice:
  - If pos==length-1: with loop set, pos=0. Without loop, play=0, done=1.
  - Otherwise pos++.
- Length 0 with play=1: contributes 0, then play=0 and done=1 at that voice's ACC.
- sample_req while not IDLE: ignored, overrun=1. The mix in progress is unaffected.
- Simultaneous host write and FSM update of the same voice register: the host write wins. This includes the restart case, which leaves pos=0 and play=1.
- Writes to reg0 or reg1 during playback take effect at the next FETCH of that voice. pos is not reset.
- Voices are mixed in index order. Identical inputs give bit-identical output.

Optional Feature:
- Macro VOICE_IRQ_EN.
- Defined: done flags are set as described above. irq = |done. reg3 clears done.
- Undefined: done flags and irq are tied to 0, and reg3 writes other than the overrun clear are ignored. Mixing behaviour is otherwise identical.

Test Plan:
- Reset mid-mix: assert resetn=0 during WAIT -> all outputs 0 and FSM IDLE. The next sample_req after release yields audio_output=0 with no voice playing.
- Single voice: voice0 start=0x100, len=4, vol=0x80, no loop; ROM[0x100..0x103]=1000,-2000,4000,32767. Four sample_req pulses -> outputs 500,-1000,2000,16383. Voice0 done=1 after the fourth, and the fifth output is 0.
- Loop wrap: same setup with loop=1 -> the fifth output is 500 again, and done stays 0.
- Saturation: 4 voices at vol=0xFF, all reading 32767 -> audio_output=32767. All reading -32768 -> audio_output=-32768.
- Overrun: pulse sample_req, then pulse again 3 cycles later -> overrun=1 and exactly one sample_valid. The reg3 write with bit15=1 to voice 0 clears overrun.
- Retrigger collision: write reg2 play=1 to voice1 in the same cycle voice1 reaches its end in ACC -> pos=0, play=1, done=0. Check irq under VOICE_IRQ_EN.
